id_ctrl_pipe: RTL and testbench

ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

---
 rtl/id_ctrl_pipe.sv | 193 +++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_pipe.sv
// ID-stage control decode with load-use stall and taken-branch flush sequencing.
// Registers the ID/EX control word and drives the IF/ID and PC enables.
module id_ctrl_pipe #(
  parameter int ACL_W        = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int HAZARD_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             beq_pc,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_mem_read,
  output logic             ex_valid,
  output logic [ACL_W-1:0] ex_acl,
  output logic [1:0]       ex_out_sel,
  output logic [1:0]       ex_src2_sel,
  output logic             if_id_write,
  output logic             pc_write,
  output logic             beq_pc_sel,
  output logic             if_id_flush,
  output logic             illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state;
  logic [1:0] flush_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  logic       dec_rw, dec_mw, dec_mr, dec_ill, uses_rs2, is_br;
  logic [3:0] dec_acl;
  logic [1:0] dec_os, dec_s2;

  logic       hazard, take_br, stall_req, branch_go, decode_slot, issue;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    dec_rw   = 1'b0;
    dec_mw   = 1'b0;
    dec_mr   = 1'b0;
    dec_ill  = 1'b0;
    uses_rs2 = 1'b0;
    is_br    = 1'b0;
    dec_acl  = 4'b0000;
    dec_os   = 2'b00;
    dec_s2   = 2'b00;
    case (opcode)
      OP_R: begin
        dec_rw   = 1'b1;
        dec_os   = 2'b01;
        dec_s2   = 2'b01;
        uses_rs2 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_acl = 4'b0000;
          10'b0100000_000: dec_acl = 4'b0001;
          10'b0000000_001: dec_acl = 4'b0010;
          10'b0000000_010: dec_acl = 4'b0011;
          10'b0000000_100: dec_acl = 4'b0100;
          10'b0000000_101: dec_acl = 4'b0101;
          10'b0000000_110: dec_acl = 4'b0110;
          10'b0000000_111: dec_acl = 4'b0111;
          default:         dec_ill = 1'b1;
        endcase
      end
      OP_I: begin
        dec_rw = 1'b1;
        dec_os = 2'b01;
        dec_s2 = 2'b10;
        // Immediate shifts and sltiu have no ALU code here, so they trap
        case (funct3)
          3'b000:  dec_acl = 4'b0000;
          3'b010:  dec_acl = 4'b0011;
          3'b100:  dec_acl = 4'b0100;
          3'b110:  dec_acl = 4'b0110;
          3'b111:  dec_acl = 4'b0111;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_rw = 1'b1;
        dec_os = 2'b10;
        dec_s2 = 2'b10;
        dec_mr = 1'b1;
      end
      OP_STORE: begin
        dec_s2   = 2'b10;
        dec_mw   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BR: begin
        dec_s2   = 2'b01;
        dec_acl  = 4'b0001;
        uses_rs2 = 1'b1;
        is_br    = 1'b1;
      end
      OP_JAL: begin
        dec_rw = 1'b1;
        dec_os = 2'b11;
      end
      OP_NOP:  ;
      default: dec_ill = 1'b1;
    endcase
  end

  assign hazard = (HAZARD_EN != 0) && instr_valid && id_ex_memread && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == rs1) || (uses_rs2 && (id_ex_rd == rs2)));
  assign take_br     = instr_valid && is_br && beq_pc;
  assign stall_req   = (state == RUN) && hazard;
  assign branch_go   = (state != FLUSH) && take_br && !stall_req;
  assign decode_slot = (state != FLUSH) && !stall_req;
  assign issue       = decode_slot && instr_valid && (opcode != OP_NOP) && !dec_ill;

  // rst gating keeps the enables at their reset values even if hazard inputs are live
  assign if_id_write = rst || !stall_req;
  assign pc_write    = rst || !stall_req;
  assign beq_pc_sel  = !rst && branch_go;
  assign if_id_flush = !rst && ((state == FLUSH) || branch_go);

  // ID -> EX boundary: sequencing state and registered control word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      flush_cnt    <= 2'd0;
      ex_reg_write <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_valid     <= 1'b0;
      ex_acl       <= '0;
      ex_out_sel   <= 2'b00;
      ex_src2_sel  <= 2'b00;
      illegal      <= 1'b0;
    end else begin
      ex_reg_write <= issue && dec_rw;
      ex_mem_write <= issue && dec_mw;
      ex_mem_read  <= issue && dec_mr;
      ex_valid     <= issue;
      ex_acl       <= issue ? ACL_W'(dec_acl) : '0;
      ex_out_sel   <= issue ? dec_os : 2'b00;
      ex_src2_sel  <= issue ? dec_s2 : 2'b00;
      illegal      <= decode_slot && instr_valid && dec_ill;
      case (state)
        RUN: begin
          if (stall_req) begin
            state <= STALL;
          end else if (branch_go) begin
            state     <= FLUSH;
            flush_cnt <= 2'(FLUSH_CYCLES - 1);
          end
        end
        STALL: begin
          if (branch_go) begin
            state     <= FLUSH;
            flush_cnt <= 2'(FLUSH_CYCLES - 1);
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt == 2'd0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: decode table plus stall, flush and reset sequences.
module tb_id_ctrl_pipe;

  localparam int ACL_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic             beq_pc;
  logic             ex_reg_write, ex_mem_write, ex_mem_read, ex_valid;
  logic [ACL_W-1:0] ex_acl;
  logic [1:0]       ex_out_sel, ex_src2_sel;
  logic             if_id_write, pc_write, beq_pc_sel, if_id_flush, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_ctrl_pipe #(.ACL_W(ACL_W), .FLUSH_CYCLES(2), .HAZARD_EN(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .beq_pc(beq_pc),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_valid(ex_valid), .ex_acl(ex_acl), .ex_out_sel(ex_out_sel), .ex_src2_sel(ex_src2_sel),
    .if_id_write(if_id_write), .pc_write(pc_write), .beq_pc_sel(beq_pc_sel),
    .if_id_flush(if_id_flush), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] BEQ = 32'h00208063;
  localparam logic [12:0] BUB = 13'h0000;
  localparam logic [12:0] ILL = 13'h0001;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        vld;
    logic        mrd;
    logic [4:0]  rd;
    logic        beq;
    logic [3:0]  comb;  // {if_id_write, pc_write, beq_pc_sel, if_id_flush}
    logic [12:0] regs;  // {rw, mw, mr, valid, acl[3:0], out_sel, src2_sel, illegal}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] ctl(input logic rw, input logic mw, input logic mr,
                                      input logic [3:0] acl, input logic [1:0] os,
                                      input logic [1:0] s2);
    return {rw, mw, mr, 1'b1, acl, os, s2, 1'b0};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] ins, input logic vld,
                               input logic mrd, input logic [4:0] rd, input logic beq,
                               input logic [3:0] comb, input logic [12:0] regs);
    vec_t v;
    v.name = nm; v.ins = ins; v.vld = vld; v.mrd = mrd; v.rd = rd; v.beq = beq;
    v.comb = comb; v.regs = regs;
    return v;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic vld, input logic mrd,
                       input logic [4:0] rd, input logic beq);
    instr = ins; instr_valid = vld; id_ex_memread = mrd; id_ex_rd = rd; beq_pc = beq;
  endtask

  task automatic chk_comb(input string nm, input logic [3:0] exp_v);
    logic [3:0] act;
    act = {if_id_write, pc_write, beq_pc_sel, if_id_flush};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s comb {ifw,pcw,sel,flush}: got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [12:0] exp_v);
    logic [12:0] act;
    act = {ex_reg_write, ex_mem_write, ex_mem_read, ex_valid, ex_acl, ex_out_sel,
           ex_src2_sel, illegal};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s regs {rw,mw,mr,v,acl,os,s2,ill}: got %b expected %b", nm, act, exp_v);
    end
  endtask

  initial begin
    vecs.push_back(mkv("add",     ADD,          1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b01,2'b01)));
    vecs.push_back(mkv("sub",     32'h402081B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0001,2'b01,2'b01)));
    vecs.push_back(mkv("sll",     32'h002091B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0010,2'b01,2'b01)));
    vecs.push_back(mkv("slt",     32'h0020A1B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0011,2'b01,2'b01)));
    vecs.push_back(mkv("xor",     32'h0020C1B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0100,2'b01,2'b01)));
    vecs.push_back(mkv("srl",     32'h0020D1B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0101,2'b01,2'b01)));
    vecs.push_back(mkv("or",      32'h0020E1B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0110,2'b01,2'b01)));
    vecs.push_back(mkv("and",     32'h0020F1B3, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0111,2'b01,2'b01)));
    vecs.push_back(mkv("addi",    32'h00508193, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b01,2'b10)));
    vecs.push_back(mkv("andi",    32'h0050F193, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0111,2'b01,2'b10)));
    vecs.push_back(mkv("lw",      32'h0000A183, 1, 0, 0, 0, 4'b1100, ctl(1,0,1,4'b0000,2'b10,2'b10)));
    vecs.push_back(mkv("sw",      32'h0020A023, 1, 0, 0, 0, 4'b1100, ctl(0,1,0,4'b0000,2'b00,2'b10)));
    vecs.push_back(mkv("beq_nt",  BEQ,          1, 0, 0, 0, 4'b1100, ctl(0,0,0,4'b0001,2'b00,2'b01)));
    vecs.push_back(mkv("jal",     32'h000000EF, 1, 0, 0, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b11,2'b00)));
    vecs.push_back(mkv("sra_ill", 32'h4020D1B3, 1, 0, 0, 0, 4'b1100, ILL));
    vecs.push_back(mkv("sltiu_ill", 32'h0050B193, 1, 0, 0, 0, 4'b1100, ILL));
    vecs.push_back(mkv("op7f_ill", 32'h0000007F, 1, 0, 0, 0, 4'b1100, ILL));
    vecs.push_back(mkv("op00_nop", 32'h00000000, 1, 0, 0, 0, 4'b1100, BUB));
    vecs.push_back(mkv("invalid", ADD,          0, 1, 1, 0, 4'b1100, BUB));
    vecs.push_back(mkv("inv_beq", BEQ,          0, 0, 0, 1, 4'b1100, BUB));
    vecs.push_back(mkv("ld_rd_other", ADD,      1, 1, 5, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b01,2'b01)));
    vecs.push_back(mkv("ld_rd_x0", 32'h000001B3, 1, 1, 0, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b01,2'b01)));
    vecs.push_back(mkv("addi_rs2_field", 32'h00208193, 1, 1, 2, 0, 4'b1100, ctl(1,0,0,4'b0000,2'b01,2'b10)));

    // Reset with hazard inputs live: enables stay high, outputs zero
    rst = 1'b1;
    drive(ADD, 1, 1, 5'd1, 1'b0);
    #12;
    chk_reg("reset_regs", BUB);
    chk_comb("reset_comb", 4'b1100);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ins, vecs[i].vld, vecs[i].mrd, vecs[i].rd, vecs[i].beq);
      #1 chk_comb(vecs[i].name, vecs[i].comb);
      @(posedge clk);
      #1 chk_reg(vecs[i].name, vecs[i].regs);
    end

    // Load-use stall: one bubble, then the add issues
    @(negedge clk); drive(ADD, 1, 1, 5'd1, 0);
    #1 chk_comb("lu_stall", 4'b0000);
    @(posedge clk); #1 chk_reg("lu_bubble", BUB);
    @(negedge clk); drive(ADD, 1, 0, 5'd0, 0);
    #1 chk_comb("lu_release", 4'b1100);
    @(posedge clk); #1 chk_reg("lu_add", ctl(1,0,0,4'b0000,2'b01,2'b01));

    // Taken branch, two flush cycles ignoring hazard and beq_pc
    @(negedge clk); drive(BEQ, 1, 0, 5'd0, 1);
    #1 chk_comb("br_take", 4'b1111);
    @(posedge clk); #1 chk_reg("br_ctl", ctl(0,0,0,4'b0001,2'b00,2'b01));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(BEQ, 1, 1, 5'd1, 1);
      #1 chk_comb($sformatf("br_flush%0d", k), 4'b1101);
      @(posedge clk); #1 chk_reg($sformatf("br_bubble%0d", k), BUB);
    end
    @(negedge clk); drive(ADD, 1, 0, 5'd0, 0);
    #1 chk_comb("br_done", 4'b1100);
    @(posedge clk); #1 chk_reg("br_add", ctl(1,0,0,4'b0000,2'b01,2'b01));

    // Hazard and branch together: stall first, branch taken in STALL
    @(negedge clk); drive(BEQ, 1, 1, 5'd2, 1);
    #1 chk_comb("hz_br_stall", 4'b0000);
    @(posedge clk); #1 chk_reg("hz_br_bubble", BUB);
    @(negedge clk); drive(BEQ, 1, 0, 5'd0, 1);
    #1 chk_comb("hz_br_take", 4'b1111);
    @(posedge clk); #1 chk_reg("hz_br_ctl", ctl(0,0,0,4'b0001,2'b00,2'b01));

    // Asynchronous reset in the middle of FLUSH
    @(negedge clk); drive(ADD, 1, 0, 5'd0, 0);
    #1 chk_comb("rf_in_flush", 4'b1101);
    #1 rst = 1'b1;
    #1 chk_reg("rf_async_regs", BUB);
    chk_comb("rf_async_comb", 4'b1100);
    #1 rst = 1'b0;
    #0 chk_comb("rf_run", 4'b1100);
    @(posedge clk); #1 chk_reg("rf_add", ctl(1,0,0,4'b0000,2'b01,2'b01));

    // Reset during STALL: first post-reset cycle stalls again, so state is RUN
    @(negedge clk); drive(ADD, 1, 1, 5'd1, 0);
    #1 chk_comb("rs_stall", 4'b0000);
    @(posedge clk); #1 chk_reg("rs_bubble", BUB);
    @(negedge clk); drive(ADD, 1, 1, 5'd1, 0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_comb("rs_run_again", 4'b0000);
    @(posedge clk); #1 chk_reg("rs_bubble2", BUB);
    @(negedge clk); drive(ADD, 1, 0, 5'd0, 0);
    #1 chk_comb("rs_release", 4'b1100);
    @(posedge clk); #1 chk_reg("rs_add", ctl(1,0,0,4'b0000,2'b01,2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
